// File: rtl/bus_pkg.sv
// Shared types and helpers for the bus generator/arbiter.
// Combinational only; no timing or backpressure of its own.
package bus_pkg;

  localparam int ID_W      = 8;
  localparam int MAX_PKT_W = 2048;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  // The destination ID lives in the top byte of a packet of width pkt_w.
  function automatic logic [ID_W-1:0] dest_id(input logic [MAX_PKT_W-1:0] pkt,
                                               input int                   pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_gen_arbiter_if.sv
// Terminal-side signal bundle for all buses: FIFO pop side and terminal push side.
// Plain wires; the arbiter is the only driver of pop/push/D_push.
interface bus_gen_arbiter_if #(
  parameter int BITS    = 1,
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 32
);

  logic [BITS-1:0][DRVRS-1:0]              pndng;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [BITS-1:0][DRVRS-1:0]              pop;
  logic [BITS-1:0][DRVRS-1:0]              push;
  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;

  // FIFO/terminal side
  modport master (
    output pndng,
    output D_pop,
    input  pop,
    input  push,
    input  D_push
  );

  // Arbiter side
  modport slave (
    input  pndng,
    input  D_pop,
    output pop,
    output push,
    output D_push
  );

endinterface

// File: rtl/bus_single_arbiter.sv
// One bus: round-robin pick of a pending terminal, pop its head, deliver to its destination(s).
// Pop 1 edge after pndng is sampled, push 2 edges after; one packet per 3 cycles, no stall input.
module bus_single_arbiter
  import bus_pkg::*;
#(
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 32,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [drvrs-1:0]               pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]  d_pop,
  output logic [drvrs-1:0]               pop,
  output logic [drvrs-1:0]               push,
  output logic [drvrs-1:0][pckg_sz-1:0]  d_push
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q,  last_d;
  logic [IDX_W-1:0]     src_q,   src_d;
  logic [pckg_sz-1:0]   pkt_q,   pkt_d;
  logic [pckg_sz-1:0]   dpush_q, dpush_d;
  logic [drvrs-1:0]     pop_q,   pop_d;
  logic [drvrs-1:0]     push_q,  push_d;

  logic                 found;
  logic [IDX_W-1:0]     win;
  logic [IDX_W-1:0]     cand;
  logic [ID_W-1:0]      id;
  logic [drvrs-1:0]     mask;

  // Scan starting just after the previous winner so nobody wins twice in a row
  // while another terminal is waiting.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 1; i <= drvrs; i++) begin
      cand = IDX_W'((int'(last_q) + i) % drvrs);
      if (!found && pndng[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Invalid IDs (not broadcast, not a terminal) yield an empty mask: the packet is dropped.
  always_comb begin
    id   = dest_id(MAX_PKT_W'(pkt_q), pckg_sz);
    mask = '0;
    if (id == broadcast) begin
      mask         = '1;
      mask[src_q]  = 1'b0;
    end else if (int'(id) < drvrs) begin
      mask[id[IDX_W-1:0]] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    pkt_d   = pkt_q;
    dpush_d = dpush_q;
    pop_d   = '0;
    push_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          pop_d[win] = 1'b1;
          pkt_d      = d_pop[win];
          src_d      = win;
          last_d     = win;
          state_d    = POP;
        end
      end
      POP: begin
        dpush_d = pkt_q;
        push_d  = mask;
        state_d = PUSH;
      end
      PUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(drvrs - 1);
      src_q   <= '0;
      pkt_q   <= '0;
      dpush_q <= '0;
      pop_q   <= '0;
      push_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      pkt_q   <= pkt_d;
      dpush_q <= dpush_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
    end
  end

  assign pop    = pop_q;
  assign push   = push_q;
  assign d_push = {drvrs{dpush_q}};

endmodule

// File: rtl/bus_gen_arbiter.sv
// Shared-bus generator: `bits` independent round-robin bus arbiters between terminal FIFOs and devices.
// Pop 1 edge and push 2 edges after a pending flag is seen; each bus moves one packet per 3 cycles.
module bus_gen_arbiter
  import bus_pkg::*;
#(
  parameter int          bits      = 1,
  parameter int          drvrs     = 4,
  parameter int          pckg_sz   = 32,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  bus_gen_arbiter_if.slave bus
);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_single_arbiter #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_arb (
      .clk    (clk),
      .reset  (reset),
      .pndng  (bus.pndng[b]),
      .d_pop  (bus.D_pop[b]),
      .pop    (bus.pop[b]),
      .push   (bus.push[b]),
      .d_push (bus.D_push[b])
    );
  end

endmodule

// File: tb/tb_bus_gen_arbiter.sv
// Bench for bus_gen_arbiter: queue-backed terminal FIFOs, timeline reference model, directed + random traffic.
module tb_bus_gen_arbiter;

  localparam int NB = 2;
  localparam int ND = 4;
  localparam int PW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_gen_arbiter_if #(.BITS(NB), .DRVRS(ND), .PCKG_SZ(PW)) bus ();

  bus_gen_arbiter #(
    .bits      (NB),
    .drvrs     (ND),
    .pckg_sz   (PW),
    .broadcast (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [PW-1:0] fq [NB][ND][$];

  int vec  = 0;
  int errs = 0;

  // Reference model: each bus is described by the edge at which it last granted.
  int            edge_n = 0;
  int            last_m  [NB];
  int            grant_e [NB];
  int            src_m   [NB];
  logic [PW-1:0] pkt_m   [NB];
  logic [PW-1:0] exp_dp  [NB];
  logic [ND-1:0] exp_pop [NB];
  logic [ND-1:0] exp_push[NB];

  function automatic logic [ND-1:0] exp_mask(input logic [PW-1:0] p, input int src);
    logic [ND-1:0] m;
    int id;
    id = int'(p[PW-1 -: 8]);
    m  = '0;
    if (id == 255) begin
      for (int t = 0; t < ND; t++) m[t] = (t != src);
    end else if (id < ND) begin
      m[id] = 1'b1;
    end
    return m;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      last_m[b]   = ND - 1;
      grant_e[b]  = -100;
      src_m[b]    = 0;
      pkt_m[b]    = '0;
      exp_dp[b]   = '0;
      exp_pop[b]  = '0;
      exp_push[b] = '0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int b = 0; b < NB; b++) begin
      if (edge_n >= grant_e[b] + 3) begin
        for (int i = 1; i <= ND; i++) begin
          int k;
          k = (last_m[b] + i) % ND;
          if (grant_e[b] != edge_n && fq[b][k].size() > 0) begin
            grant_e[b] = edge_n;
            src_m[b]   = k;
            last_m[b]  = k;
            pkt_m[b]   = fq[b][k][0];
          end
        end
      end
      exp_pop[b] = (edge_n == grant_e[b]) ? ND'(1 << src_m[b]) : '0;
      if (edge_n == grant_e[b] + 1) begin
        exp_dp[b]   = pkt_m[b];
        exp_push[b] = exp_mask(pkt_m[b], src_m[b]);
      end else begin
        exp_push[b] = '0;
      end
    end
  endtask

  task automatic drive();
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < ND; d++) begin
        bus.pndng[b][d] = (fq[b][d].size() > 0);
        bus.D_pop[b][d] = (fq[b][d].size() > 0) ? fq[b][d][0] : PW'($urandom());
      end
  endtask

  // Advance one clock; the terminal FIFOs drop their head when the DUT pops them.
  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    #1;
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < ND; d++)
        if (bus.pop[b][d] && fq[b][d].size() > 0) void'(fq[b][d].pop_front());
    drive();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive();
    model_reset();
    #2;
    vec++;
    if (bus.pop !== '0 || bus.push !== '0 || bus.D_push !== '0) begin
      errs++;
      $display("FAIL reset_async pop=%h push=%h dpush=%h want 0", bus.pop, bus.push, bus.D_push);
    end
    repeat (2) step();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      vec++;
      if (bus.pop !== '0 || bus.push !== '0 || bus.D_push !== '0) begin
        errs++;
        $display("FAIL idle_quiet cyc%0d pop=%h push=%h dpush=%h want 0", c, bus.pop, bus.push, bus.D_push);
      end
    end
  endtask

  task automatic test_unicast();
    fq[0][1].push_back(32'h0200ABCD);
    drive();
    step();
    vec++;
    if (bus.pop[0] !== 4'b0010 || bus.pop[1] !== 4'b0000 || bus.push[0] !== 4'b0000) begin
      errs++;
      $display("FAIL uni_pop pop0=%b pop1=%b push0=%b want 0010/0000/0000", bus.pop[0], bus.pop[1], bus.push[0]);
    end
    step();
    vec++;
    if (bus.pop[0] !== 4'b0000 || bus.push[0] !== 4'b0100) begin
      errs++;
      $display("FAIL uni_push pop0=%b push0=%b want 0000/0100", bus.pop[0], bus.push[0]);
    end
    for (int d = 0; d < ND; d++) begin
      vec++;
      if (bus.D_push[0][d] !== 32'h0200ABCD) begin
        errs++;
        $display("FAIL uni_data term%0d got %h want 0200abcd", d, bus.D_push[0][d]);
      end
    end
    step();
    vec++;
    if (bus.push[0] !== 4'b0000 || bus.D_push[0][3] !== 32'h0200ABCD) begin
      errs++;
      $display("FAIL uni_done push0=%b dpush=%h want 0000/0200abcd", bus.push[0], bus.D_push[0][3]);
    end
  endtask

  task automatic test_broadcast();
    fq[0][3].push_back(32'hFF123456);
    drive();
    step();
    vec++;
    if (bus.pop[0] !== 4'b1000) begin
      errs++;
      $display("FAIL bc_pop got %b want 1000", bus.pop[0]);
    end
    step();
    vec++;
    if (bus.push[0] !== 4'b0111 || bus.D_push[0][0] !== 32'hFF123456) begin
      errs++;
      $display("FAIL bc_push push=%b dpush=%h want 0111/ff123456", bus.push[0], bus.D_push[0][0]);
    end
    step();
  endtask

  task automatic test_round_robin();
    for (int d = 0; d < ND; d++)
      for (int n = 0; n < 6; n++)
        fq[0][d].push_back({8'((d + 1) % ND), 8'(d), 16'(n)});
    drive();
    for (int e = 0; e < 15; e++) begin
      int k;
      logic [ND-1:0] wp, wq;
      logic [PW-1:0] wd;
      step();
      k  = (e / 3) % ND;
      wp = (e % 3 == 0) ? ND'(1 << k) : '0;
      wq = (e % 3 == 1) ? ND'(1 << ((k + 1) % ND)) : '0;
      wd = {8'((k + 1) % ND), 8'(k), 16'((e / 3) / ND)};
      vec++;
      if (bus.pop[0] !== wp || bus.push[0] !== wq) begin
        errs++;
        $display("FAIL rr_strobe e%0d pop=%b push=%b want %b/%b", e, bus.pop[0], bus.push[0], wp, wq);
      end
      if (e % 3 == 1) begin
        vec++;
        if (bus.D_push[0][0] !== wd) begin
          errs++;
          $display("FAIL rr_data e%0d got %h want %h", e, bus.D_push[0][0], wd);
        end
      end
      if (e == 14) begin
        for (int d = 0; d < ND; d++) fq[0][d].delete();
        drive();
      end
    end
  endtask

  task automatic test_invalid();
    fq[0][0].push_back(32'h07000001);
    drive();
    step();
    vec++;
    if (bus.pop[0] !== 4'b0001) begin
      errs++;
      $display("FAIL inv_pop got %b want 0001", bus.pop[0]);
    end
    fq[0][2].push_back(32'h010000AA);
    drive();
    step();
    vec++;
    if (bus.push[0] !== 4'b0000 || bus.pop[0] !== 4'b0000) begin
      errs++;
      $display("FAIL inv_drop push=%b pop=%b want 0000/0000", bus.push[0], bus.pop[0]);
    end
    step();
    step();
    vec++;
    if (bus.pop[0] !== 4'b0100) begin
      errs++;
      $display("FAIL inv_next_pop got %b want 0100", bus.pop[0]);
    end
    step();
    vec++;
    if (bus.push[0] !== 4'b0010) begin
      errs++;
      $display("FAIL inv_next_push got %b want 0010", bus.push[0]);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fq[0][1].push_back(32'h0300BEEF);
    drive();
    step();
    vec++;
    if (bus.pop[0] !== 4'b0010) begin
      errs++;
      $display("FAIL rm_pop got %b want 0010", bus.pop[0]);
    end
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    vec++;
    if (bus.pop !== '0 || bus.push !== '0 || bus.D_push !== '0) begin
      errs++;
      $display("FAIL rm_abort pop=%h push=%h dpush=%h want 0", bus.pop, bus.push, bus.D_push);
    end
    step();
    step();
    vec++;
    if (bus.push[0] !== 4'b0000) begin
      errs++;
      $display("FAIL rm_no_push got %b want 0000", bus.push[0]);
    end
    reset = 1'b1;
    fq[0][0].push_back(32'h01000011);
    fq[0][3].push_back(32'h00000033);
    drive();
    step();
    vec++;
    if (bus.pop[0] !== 4'b0001) begin
      errs++;
      $display("FAIL rm_prio got %b want 0001", bus.pop[0]);
    end
    step();
    vec++;
    if (bus.push[0] !== 4'b0010 || bus.D_push[0][2] !== 32'h01000011) begin
      errs++;
      $display("FAIL rm_deliver push=%b dpush=%h want 0010/01000011", bus.push[0], bus.D_push[0][2]);
    end
  endtask

  task automatic test_random();
    int busy;
    for (int c = 0; c < 1200; c++) begin
      if (c < 900 && $urandom_range(0, 3) == 0) begin
        int b, d, r;
        logic [7:0] id;
        b = $urandom_range(0, NB - 1);
        d = $urandom_range(0, ND - 1);
        r = $urandom_range(0, 9);
        if (r < 6)      id = 8'($urandom_range(0, ND - 1));
        else if (r < 8) id = 8'hFF;
        else            id = 8'($urandom_range(4, 254));
        if (fq[b][d].size() < 4) fq[b][d].push_back({id, 24'($urandom())});
        drive();
      end
      step();
      for (int b = 0; b < NB; b++) begin
        vec++;
        if (bus.pop[b] !== exp_pop[b]) begin
          errs++;
          $display("FAIL rnd_pop c%0d bus%0d got %b want %b", c, b, bus.pop[b], exp_pop[b]);
        end
        vec++;
        if (bus.push[b] !== exp_push[b]) begin
          errs++;
          $display("FAIL rnd_push c%0d bus%0d got %b want %b", c, b, bus.push[b], exp_push[b]);
        end
        vec++;
        if (bus.D_push[b][$urandom_range(0, ND - 1)] !== exp_dp[b]) begin
          errs++;
          $display("FAIL rnd_data c%0d bus%0d got %h want %h", c, b, bus.D_push[b][0], exp_dp[b]);
        end
        vec++;
        if ($countones(bus.pop[b]) > 1 || (bus.pop[b] != '0 && bus.push[b] != '0)) begin
          errs++;
          $display("FAIL rnd_excl c%0d bus%0d pop=%b push=%b want onehot0/exclusive", c, b, bus.pop[b], bus.push[b]);
        end
      end
    end
    busy = 0;
    for (int b = 0; b < NB; b++)
      for (int d = 0; d < ND; d++) busy += fq[b][d].size();
    vec++;
    if (busy != 0) begin
      errs++;
      $display("FAIL rnd_drain %0d packets left want 0", busy);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.pndng = '0;
    bus.D_pop = '0;
    model_reset();
    test_reset();
    test_unicast();
    test_broadcast();
    test_round_robin();
    test_invalid();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/bus_gen_arbiter.md
Name: bus_gen_arbiter

Overview:
Shared-bus generator and round-robin arbiter connecting `drvrs` terminals, each fronted by an external FIFO.
- Per bus: the arbiter picks one terminal with pending data and pops its head packet.
- It decodes the 8-bit destination ID in the packet MSBs.
- It pushes the packet into the destination terminal's input, or into all other terminals on broadcast.
- It sits between the terminal FIFOs and the terminal devices. `bits` independent buses are supported.

Parameters:
- bits, 1, number of independent parallel buses.
- drvrs, 4, number of terminals per bus (legal 2..255).
- pckg_sz, 32, packet width in bits; [pckg_sz-1:pckg_sz-8] = destination ID, rest = payload (pckg_sz >= 9).
- broadcast, 8'hFF, destination ID meaning "all terminals except source".

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (name kept as in codebase; low = reset).
- pndng  in  [bits-1:0][drvrs-1:0]  terminal FIFO non-empty flag.
- D_pop  in  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  FIFO head data; valid whenever pndng=1.
- pop  out  [bits-1:0][drvrs-1:0]  one-cycle pop strobe to terminal FIFO.
- push  out  [bits-1:0][drvrs-1:0]  one-cycle write strobe to terminal.
- D_push  out  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  delivered packet; same value on every terminal of a bus.

Behaviour:
- Reset asserted (low), asynchronously:
  - all pop, push and D_push = 0;
  - FSM = IDLE;
  - round-robin pointer last = drvrs-1, so terminal 0 has top priority first.
- Buses are fully independent; each has its own FSM, pointer and packet register.
- FSM states IDLE, POP, PUSH. All outputs are registered.
- IDLE:
  - If any pndng bit is set, winner k = first set bit scanning last+1, last+2, … modulo drvrs.
  - At the edge: pop[k]<=1, pkt<=D_pop[k], src<=k, last<=k, state<=POP.
  - Else stay in IDLE.
- POP (pop[k] high this cycle; FIFO removes head at next edge):
  - At the edge: pop<=0, D_push<=pkt on all terminals.
  - push mask: ID==broadcast -> all terminals except src; ID<drvrs -> only terminal ID, including ID==src; otherwise (invalid ID) all zero, packet silently dropped.
  - state<=PUSH.
- PUSH (push high this cycle): at the edge push<=0, state<=IDLE. D_push holds its value until the next delivery.
- Throughput: one packet per 3 cycles per bus. Latency from pndng sampled to push high = 2 edges.
- At most one pop bit per bus is high in any cycle; pop and push are never high in the same cycle on the same bus.
- pndng changes in POP/PUSH are ignored; arbitration occurs only in IDLE.
- Simultaneous requests: strict round robin, so no terminal wins twice while another stays pending.
- Reset mid-transaction aborts it: strobes drop immediately and the latched packet is discarded. A pop already issued is not replayed.

Decomposition:
- Shared package bus_pkg:
  - ID_W = 8 localparam;
  - state enum {IDLE, POP, PUSH};
  - function dest_id(pkt) extracting the MSB byte.
- Natural sub-module bus_single_arbiter: one bus's FSM, round-robin pointer and decoder.
- Top generates `bits` instances of bus_single_arbiter.

Test Plan:
- Reset held low, pndng=0 -> pop=0, push=0, D_push=0. After release with no pndng, outputs stay 0 indefinitely.
- Terminal 1 pending with D_pop=32'h02_00ABCD -> pop[1] high one cycle, next cycle push[2] high only, D_push=32'h0200ABCD on all terminals.
- Terminal 3 pending with D_pop=32'hFF_123456 -> push mask 4'b0111, D_push=32'hFF123456.
- pndng=4'b1111 held continuously, each head addressed to (src+1)%4 -> pops in order 0,1,2,3,0, spaced 3 cycles apart.
- D_pop=32'h07_000001 from terminal 0 (ID >= drvrs) -> pop[0] fires, no push bit set, FSM returns to IDLE.
- Assert reset during POP -> pop drops asynchronously. After release, terminal 0 wins the next arbitration.
